ram_access_ctrl: RTL and testbench

- Sequences every access to the 16x8 program/data RAM.
- Shares the RAM between two requesters:
  - requester 0: CPU fetch/execute path.
  - requester 1: external program loader.
- Generates the RAM control lines (address, pc_in select, OE_n, EN) and the RAM_BUS drive controls, and returns read data with a done pulse.
- Sits between the control unit / loader and the ram instance; the top level owns the tristate on RAM_BUS.

---
 rtl/ram_ctrl_pkg.sv | 18 +
 rtl/arb2.sv | 42 ++++
 rtl/ram_access_ctrl.sv | 114 +++++++++++
 tb/tb_ram_access_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the 16x8 RAM access controller.
// Used by ram_access_ctrl and its arbiter arb2.
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  localparam int REQ_CPU    = 0;
  localparam int REQ_LOADER = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    TURN   = 2'd3
  } state_t;

endpackage

// File: rtl/arb2.sv
// Two-input arbiter: one-hot grant plus winner index.
// RAM_ACCESS_CTRL_RR_EN selects round-robin; otherwise the loader wins ties.
module arb2
  import ram_ctrl_pkg::*;
(
`ifdef RAM_ACCESS_CTRL_RR_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       update,
`endif
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       idx
);

`ifdef RAM_ACCESS_CTRL_RR_EN
  // ptr_reg names the requester favoured on the next tie
  logic ptr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= 1'b0;
    end else if (update) begin
      ptr_reg <= ~idx;
    end
  end

  always_comb begin
    idx = (req == 2'b11) ? ptr_reg : req[REQ_LOADER];
  end
`else
  always_comb begin
    idx = req[REQ_LOADER];
  end
`endif

  always_comb begin
    gnt = 2'b00;
    if (|req) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Sequences CPU/loader accesses to the 16x8 RAM: IDLE -> SETUP -> ACCESS -> TURN.
// Arbitration mode set by RAM_ACCESS_CTRL_RR_EN (round-robin) or fixed loader priority.
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_pc_in,
  output logic              ram_oe_n,
  output logic              ram_en,
  output logic [DATA_W-1:0] ram_bus_out,
  output logic              ram_bus_oe,
  input  logic [DATA_W-1:0] ram_bus_in
);

  state_t            state_reg;
  logic              owner_reg;
  logic              we_reg;
  logic [DATA_W-1:0] wdata_reg;

  logic [1:0]        arb_gnt;
  logic              arb_idx;
  logic              grant_make;

  assign grant_make = (state_reg == IDLE) && (|req);

  arb2 u_arb (
`ifdef RAM_ACCESS_CTRL_RR_EN
    .clk    (clk),
    .rst_n  (rst_n),
    .update (grant_make),
`endif
    .req    (req),
    .gnt    (arb_gnt),
    .idx    (arb_idx)
  );

  // Every RAM-facing output is set on the edge entering the state it belongs to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      owner_reg   <= 1'b0;
      we_reg      <= 1'b0;
      wdata_reg   <= '0;
      gnt         <= 2'b00;
      done        <= 2'b00;
      rdata       <= '0;
      busy        <= 1'b0;
      ram_addr    <= '0;
      ram_pc_in   <= 1'b0;
      ram_oe_n    <= 1'b1;
      ram_en      <= 1'b0;
      ram_bus_out <= '0;
      ram_bus_oe  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_make) begin
            state_reg <= SETUP;
            owner_reg <= arb_idx;
            we_reg    <= we[arb_idx];
            wdata_reg <= arb_idx ? wdata1 : wdata0;
            ram_addr  <= arb_idx ? addr1 : addr0;
            ram_pc_in <= we[arb_idx];
            gnt       <= arb_gnt;
            busy      <= 1'b1;
          end
        end
        SETUP: begin
          state_reg <= ACCESS;
          if (we_reg) begin
            ram_en      <= 1'b1;
            ram_bus_oe  <= 1'b1;
            ram_bus_out <= wdata_reg;
          end else begin
            ram_oe_n <= 1'b0;
          end
        end
        ACCESS: begin
          state_reg  <= TURN;
          ram_en     <= 1'b0;
          ram_bus_oe <= 1'b0;
          ram_oe_n   <= 1'b1;
          if (!we_reg) rdata <= ram_bus_in;
          done[owner_reg] <= 1'b1;
        end
        TURN: begin
          state_reg <= IDLE;
          done      <= 2'b00;
          gnt       <= 2'b00;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural 16x8 RAM and a result scoreboard.
// Expectations for tied requests follow RAM_ACCESS_CTRL_RR_EN.
module tb_ram_access_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] we;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic [1:0] gnt, done;
  logic [7:0] rdata;
  logic       busy;
  logic [3:0] ram_addr;
  logic       ram_pc_in, ram_oe_n, ram_en, ram_bus_oe;
  logic [7:0] ram_bus_out, ram_bus_in;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] g;
    bit         rd;
    logic [7:0] rv;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic [7:0] mem [16];

  always #5 clk = ~clk;

  ram_access_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .we          (we),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .gnt         (gnt),
    .done        (done),
    .rdata       (rdata),
    .busy        (busy),
    .ram_addr    (ram_addr),
    .ram_pc_in   (ram_pc_in),
    .ram_oe_n    (ram_oe_n),
    .ram_en      (ram_en),
    .ram_bus_out (ram_bus_out),
    .ram_bus_oe  (ram_bus_oe),
    .ram_bus_in  (ram_bus_in)
  );

  // Behavioural RAM: drives the bus while OE_n is low, commits on a clock edge with EN high
  assign ram_bus_in = ram_oe_n ? 8'h00 : mem[ram_addr];

  always @(posedge clk) begin
    if (ram_en) mem[ram_addr] <= ram_bus_oe ? ram_bus_out : 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Per-cycle monitor: bus-fight and done-width checks, scoreboard pop on done
  logic [1:0] prev_done  = 2'b00;
  logic [7:0] prev_rdata = 8'h00;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ram_bus_oe) chk("bus_fight_oe_n", {31'd0, ram_oe_n}, 32'd1);
      if (done != 2'b00) begin
        chk("done_two_cycles", {30'd0, prev_done}, 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_done", {30'd0, done}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          $display("txn done gnt=%b done=%b rdata=%02h", gnt, done, rdata);
          chk("sb_gnt", {30'd0, gnt}, {30'd0, mon_e.g});
          chk("sb_done", {30'd0, done}, {30'd0, mon_e.g});
          if (mon_e.rd) chk("sb_rdata", {24'd0, rdata}, {24'd0, mon_e.rv});
          else          chk("sb_rdata_hold", {24'd0, rdata}, {24'd0, prev_rdata});
        end
      end
    end
    prev_done  = done;
    prev_rdata = rdata;
  end

  // One transaction from requester r; drop=1 releases req (and scrambles addr) during SETUP
  task automatic txn(input int r, input bit w, input logic [3:0] a, input logic [7:0] d,
                     input logic [7:0] exp_rd, input bit drop);
    logic [1:0] g;
    int en_cnt, en_at, boe_cnt, done_cnt, done_at;
    g = 2'b00;
    g[r] = 1'b1;
    en_cnt = 0; en_at = 0; boe_cnt = 0; done_cnt = 0; done_at = 0;
    @(negedge clk);
    req[r] = 1'b1;
    we[r]  = w;
    if (r == 0) begin addr0 = a; wdata0 = d; end
    else        begin addr1 = a; wdata1 = d; end
    sb.push_back('{g: g, rd: !w, rv: exp_rd});
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("setup_addr", {28'd0, ram_addr}, {28'd0, a});
        chk("setup_pc_in", {31'd0, ram_pc_in}, {31'd0, w});
        chk("setup_busy", {31'd0, busy}, 32'd1);
        if (drop) begin
          req[r] = 1'b0;
          if (r == 0) addr0 = ~a; else addr1 = ~a;
        end
      end
      if (k == 2) chk("access_addr_held", {28'd0, ram_addr}, {28'd0, a});
      if (ram_en) begin en_cnt++; en_at = k; end
      if (ram_bus_oe) boe_cnt++;
      if (done[r]) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
        req[r] = 1'b0;
      end
    end
    we[r] = 1'b0;
    chk("done_count", done_cnt, 1);
    chk("done_latency", done_at, 3);
    if (w) begin
      chk("en_width", en_cnt, 1);
      chk("en_latency", en_at, 2);
    end else begin
      chk("read_bus_oe", boe_cnt, 0);
    end
  endtask

  initial begin
    bit found;
    int n, last;
    logic [1:0] cg;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    req = 2'b00; we = 2'b00;
    addr0 = 4'h0; addr1 = 4'h0; wdata0 = 8'h00; wdata1 = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    chk("rst_done", {30'd0, done}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_oe_n", {31'd0, ram_oe_n}, 32'd1);
    chk("rst_en", {31'd0, ram_en}, 32'd0);
    chk("rst_bus_oe", {31'd0, ram_bus_oe}, 32'd0);
    chk("rst_pc_in", {31'd0, ram_pc_in}, 32'd0);
    chk("rst_addr", {28'd0, ram_addr}, 32'd0);
    chk("rst_bus_out", {24'd0, ram_bus_out}, 32'd0);
    rst_n = 1'b1;

    // Loader write/read at address 0
    txn(1, 1'b1, 4'h0, 8'hAA, 8'h00, 1'b0);
    txn(1, 1'b0, 4'h0, 8'h00, 8'hAA, 1'b0);
    // CPU write/read at top address
    txn(0, 1'b1, 4'hF, 8'h55, 8'h00, 1'b0);
    txn(0, 1'b0, 4'hF, 8'h00, 8'h55, 1'b0);
    // Request dropped during SETUP still completes with latched address
    txn(1, 1'b1, 4'h4, 8'hCC, 8'h00, 1'b0);
    txn(0, 1'b0, 4'h4, 8'h00, 8'hCC, 1'b1);

    // Asynchronous reset in the middle of a write's ACCESS cycle
    @(negedge clk);
    req = 2'b10; we = 2'b10; addr1 = 4'h5; wdata1 = 8'h77;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (ram_en) found = 1'b1;
    end
    chk("rst_reach_access", {31'd0, found}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_en", {31'd0, ram_en}, 32'd0);
    chk("abort_oe_n", {31'd0, ram_oe_n}, 32'd1);
    chk("abort_bus_oe", {31'd0, ram_bus_oe}, 32'd0);
    req = 2'b00; we = 2'b00;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_gnt", {30'd0, gnt}, 32'd0);
    txn(1, 1'b0, 4'h5, 8'h00, 8'h00, 1'b0);

    // Continuous contention, reads of address 2, starting from a fresh pointer
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
`ifdef RAM_ACCESS_CTRL_RR_EN
      cg = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      cg = 2'b10;
`endif
      sb.push_back('{g: cg, rd: 1'b1, rv: 8'h00});
    end
    req = 2'b11; we = 2'b00; addr0 = 4'h2; addr1 = 4'h2;
    n = 0; last = 0;
    for (int k = 1; k <= 40 && n < 4; k++) begin
      @(negedge clk);
      if (done != 2'b00) begin
        if (n > 0) chk("contend_period", k - last, 4);
        last = k;
        n++;
        if (n == 4) req = 2'b00;
      end
    end
    chk("contend_count", n, 4);
    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
